// File: rtl/pipe_cskip_adder.sv
// ---------------------------------------------------------------------------
// pipe_cskip_adder
//   Pipelined carry-skip adder with valid/ready handshakes on both sides.
//   The WIDTH-bit add is split into NBLK = WIDTH/BLK blocks. Pipeline
//   register k holds the partial sum for blocks 0..k, the carry out of
//   block k and the operands. The sum bits of block k are formed while
//   the data is loaded into register k. The last register drives the
//   outputs directly.
//
//   Optional feature macro: PIPE_CSKIP_OVF_EN
//     Adds port ovf, the two's-complement signed overflow flag.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   a/b/cin hold a valid operand set
//   in_ready   out  operand set is accepted this cycle (combinational)
//   a, b       in   WIDTH-bit unsigned addends
//   cin        in   carry in
//   out_valid  out  sum/cout(/ovf) hold a valid result
//   out_ready  in   downstream takes the result this cycle
//   sum        out  (a+b+cin) mod 2^WIDTH
//   cout       out  carry out of the MSB
//   ovf        out  signed overflow (only with PIPE_CSKIP_OVF_EN)
// ---------------------------------------------------------------------------
module pipe_cskip_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_CSKIP_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = WIDTH / BLK;

  generate
    if ((BLK < 1) || ((WIDTH % BLK) != 0)) begin : g_bad_cfg
      $error("pipe_cskip_adder: WIDTH must be a positive multiple of BLK");
    end
  endgenerate

  // One carry-skip block: ripple sum, and the block carry bypasses the
  // ripple chain when every bit propagates. Returns {carry_out, sum}.
  function automatic logic [BLK:0] cskip_blk(input logic [BLK-1:0] x,
                                             input logic [BLK-1:0] y,
                                             input logic           c);
    logic [BLK-1:0] s;
    logic           rc;
    logic           bp;
    rc = c;
    for (int i = 0; i < BLK; i++) begin
      s[i] = x[i] ^ y[i] ^ rc;
      rc   = (x[i] & y[i]) | (rc & (x[i] ^ y[i]));
    end
    bp = &(x ^ y);
    return {(bp ? c : rc), s};
  endfunction

  logic [NBLK-1:0]            v_q, v_d;
  logic [NBLK-1:0]            c_q, c_d;
  logic [NBLK-1:0][WIDTH-1:0] a_q, b_q, s_q, s_d;
  logic [NBLK-1:0][WIDTH-1:0] src_a_s, src_b_s, src_s_s;
  logic [NBLK-1:0]            src_c_s;
  logic [NBLK-1:0][BLK:0]     blk_s;
  logic [NBLK-1:0]            adv_s;
  logic [NBLK-1:0]            ld_s;
  logic                       accept_s;

  // Stage inputs: stage 0 takes the ports, stage k takes register k-1.
  generate
    if (NBLK == 1) begin : g_one
      assign src_a_s[0] = a;
      assign src_b_s[0] = b;
      assign src_c_s[0] = cin;
      assign src_s_s[0] = {WIDTH{1'b0}};
      assign ld_s[0]    = accept_s;
    end else begin : g_multi
      assign src_a_s = {a_q[NBLK-2:0], a};
      assign src_b_s = {b_q[NBLK-2:0], b};
      assign src_c_s = {c_q[NBLK-2:0], cin};
      assign src_s_s = {s_q[NBLK-2:0], {WIDTH{1'b0}}};
      assign ld_s    = {adv_s[NBLK-2:0], accept_s};
    end
  endgenerate

  // Advance flags. A stage moves when the output is being taken or any
  // stage further down is empty; this is the unrolled form of
  // "next stage empty or advancing".
  always_comb begin
    logic full_dn;
    full_dn = 1'b1;
    for (int k = NBLK - 1; k >= 0; k--) begin
      adv_s[k] = v_q[k] & (out_ready | ~full_dn);
      full_dn  = full_dn & v_q[k];
    end
  end

  assign in_ready = ~rst & (~v_q[0] | adv_s[0]);
  assign accept_s = in_valid & in_ready;

  // Per-stage block add and next-state valid flags.
  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      blk_s[k] = cskip_blk(src_a_s[k][k*BLK +: BLK],
                           src_b_s[k][k*BLK +: BLK], src_c_s[k]);
      s_d[k]   = src_s_s[k];
      s_d[k][k*BLK +: BLK] = blk_s[k][BLK-1:0];
      c_d[k]   = blk_s[k][BLK];
      v_d[k]   = ld_s[k] | (v_q[k] & ~adv_s[k]);
    end
  end

  // Pipeline registers; data only changes when a stage is loaded so a
  // stalled output holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < NBLK; k++) begin
        if (ld_s[k]) begin
          a_q[k] <= src_a_s[k];
          b_q[k] <= src_b_s[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
    end
  end

  // Operands are not needed once the last block has been added.
  logic unused_s;
  assign unused_s = ^{a_q[NBLK-1], b_q[NBLK-1]};

  assign out_valid = v_q[NBLK-1];
  assign sum       = s_q[NBLK-1];
  assign cout      = c_q[NBLK-1];

`ifdef PIPE_CSKIP_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = (src_a_s[NBLK-1][WIDTH-1] == src_b_s[NBLK-1][WIDTH-1]) &
                 (s_d[NBLK-1][WIDTH-1] != src_a_s[NBLK-1][WIDTH-1]);

  // Overflow flag registered alongside the final sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ld_s[NBLK-1]) begin
      ovf_q <= ovf_d;
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_cskip_adder.sv
// Testbench for pipe_cskip_adder (WIDTH=16, BLK=4). A queue-based model of
// the handshake pipeline predicts every output on each falling edge. Directed
// sequences pin the latency and exact sums with literal values.
module tb_pipe_cskip_adder;
  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
`ifdef PIPE_CSKIP_OVF_EN
  logic        ovf;
`endif

  pipe_cskip_adder #(.WIDTH(16), .BLK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PIPE_CSKIP_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input int t);
    exp_t        m;
    logic [16:0] tot;
    tot = {1'b0, x} + {1'b0, y} + {16'h0, c};
    m.s = tot[15:0];
    m.c = tot[16];
    m.o = (x[15] == y[15]) && (tot[15] != x[15]);
    m.t = t;
    return m;
  endfunction

  // Compare process: an item leaves NB cycles after acceptance unless an
  // older item still blocks the output; capacity is NB items.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("in_ready_during_rst", {31'h0, in_ready}, 32'h0);
      q.delete();
    end else begin
      chk("in_ready", {31'h0, in_ready}, {31'h0, (q.size() < NB) || out_ready});
      chk("out_valid", {31'h0, out_valid},
          {31'h0, (q.size() > 0) && ((cyc - q[0].t) >= NB)});
      if (out_valid && (q.size() > 0)) begin
        chk("sum", {16'h0, sum}, {16'h0, q[0].s});
        chk("cout", {31'h0, cout}, {31'h0, q[0].c});
`ifdef PIPE_CSKIP_OVF_EN
        chk("ovf", {31'h0, ovf}, {31'h0, q[0].o});
`endif
      end
      if (out_valid && out_ready && (q.size() > 0)) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(a, b, cin, cyc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single operand set into an empty pipe; checks exact latency and value.
  task automatic one(input string nm, input logic [15:0] x, input logic [15:0] y,
                     input logic c, input logic [15:0] es, input logic ec, input logic eo);
    in_valid = 1'b1; a = x; b = y; cin = c;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk({nm, "_early"}, {31'h0, out_valid}, 32'h0);
    step();
    @(negedge clk);
    chk({nm, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({nm, "_sum"}, {16'h0, sum}, {16'h0, es});
    chk({nm, "_cout"}, {31'h0, cout}, {31'h0, ec});
`ifdef PIPE_CSKIP_OVF_EN
    chk({nm, "_ovf"}, {31'h0, ovf}, {31'h0, eo});
`else
    if (eo === 1'bx) $display("note: %s", nm);
`endif
    step();
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    int acc;
    int drained;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_sum", {16'h0, sum}, 32'h0);
    chk("rst_cout", {31'h0, cout}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef PIPE_CSKIP_OVF_EN
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
`endif
    step();

    one("one_plus_one", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    one("skip_chain",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    one("ovf_pos",      16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    one("ovf_neg",      16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    one("wrap",         16'hF0F0, 16'h1F10, 1'b1, 16'h1001, 1'b1, 1'b0);

    // Back-to-back stream of eight sets.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1; a = 16'(i); b = 16'(16'h1111 * i); cin = 1'b0;
          step();
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          chk("stream_valid", {31'h0, out_valid}, {31'h0, k >= 4});
          if (k >= 4) chk("stream_sum", {16'h0, sum}, 32'(16'(16'h1112 * (k - 4))));
        end
      end
    join
    step();

    // Backpressure: pipe fills to NB entries, then drains in order.
    repeat (4) step();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom());
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("stall_accepts", 32'(acc), 32'd4);
    @(negedge clk);
    chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
    chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
    step();
    out_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) drained++;
      step();
    end
    chk("stall_drained", 32'(drained), 32'd4);

    // Reset with three sets in flight: none of them may appear.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = pick(); b = pick(); cin = 1'b0;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("flush_no_valid", {31'h0, out_valid}, 32'h0);
      step();
    end
    one("after_flush", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 700; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom());
      out_ready = (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_cskip_adder.md
PIPE_CSKIP_ADDER -- requirements
Module: pipe_cskip_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter BLK, default 4, carry-skip block width in bits; WIDTH SHALL be an integer multiple of BLK, and any other value SHALL fail elaboration; NBLK = WIDTH/BLK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operand set a/b/cin is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  addend A, unsigned.
REQ-008 b  input  WIDTH  addend B, unsigned.
REQ-009 cin  input  1  carry in.
REQ-010 out_valid  output  1  sum/cout/ovf hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of the MSB.
REQ-014 ovf  output  1  two's-complement signed overflow; present only with PIPE_CSKIP_OVF_EN.

Function
REQ-015 The datapath SHALL have NBLK register stages; stage k computes sum bits [k*BLK+BLK-1 : k*BLK] from the stage-k carry and forwards the remaining operand bits, the partial sum and the block carry to stage k+1.
REQ-016 Each block SHALL ripple-add its BLK bits, form propagate p = a^b per bit and bp = AND of p, and select block carry-out = carry-in when bp=1, else the ripple carry.
REQ-017 An operand set is accepted on a cycle with in_valid=1 and in_ready=1; the result SHALL appear with out_valid=1 exactly NBLK cycles later when no backpressure occurs.
REQ-018 Stage k advances when it holds valid data and stage k+1 is empty or advancing; the last stage advances when out_ready=1.
REQ-019 in_ready = (stage 0 empty) OR (stage 0 advancing), combinationally; throughput SHALL be one result per cycle while out_ready=1.
REQ-020 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL remain stable and no accepted data SHALL be lost or duplicated; the pipeline SHALL fill to NBLK entries, then deassert in_ready.
REQ-021 Simultaneous accept at stage 0 and drain at the output in the same cycle SHALL both take effect.
REQ-022 Results SHALL leave in acceptance order.
REQ-023 Carry wrap-around: a+b+cin >= 2^WIDTH SHALL give cout=1 and sum = (a+b+cin) - 2^WIDTH.
REQ-024 in_valid=0 SHALL insert a bubble; the bubble SHALL never produce out_valid=1.

Reset
REQ-025 While rst=1 at a clock edge, all stage valid flags SHALL clear; out_valid=0, sum=0, cout=0, ovf=0 after that edge.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight operand sets; no result for them SHALL ever appear.
REQ-027 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro PIPE_CSKIP_OVF_EN defined: port ovf exists and equals (a[MSB]==b[MSB]) AND (sum[MSB]!=a[MSB]), aligned with its sum.
REQ-029 Macro PIPE_CSKIP_OVF_EN undefined: port ovf and its logic are absent; all other behaviour is identical.

Verification (WIDTH=16, BLK=4, latency 4)
REQ-030 a=0x0001, b=0x0001, cin=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0002, cout=0.
REQ-031 a=0xFFFF, b=0x0000, cin=1 (every block bp=1, full skip chain) -> sum=0x0000, cout=1.
REQ-032 Back-to-back stream of 8 sets {a=i, b=0x1111*i}, out_ready=1 -> 8 consecutive out_valid cycles in order, sum=0x1112*i (i=0..7).
REQ-033 out_ready=0 for 10 cycles during a stream -> in_ready drops after 4 accepts, sum held stable; on release all 4 results drain in order.
REQ-034 rst=1 for one cycle with 3 sets in flight -> out_valid stays 0 until a new set is accepted, then exactly 4 cycles later.
REQ-035 With PIPE_CSKIP_OVF_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
